// File: rtl/alu_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist_ctrl_if
// Brief    : Operand/result bus between the ALU self-test controller and the
//            reference/structural ALU pair.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_bist_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             c_out;
    logic [2:0]       func_out;
    logic [WIDTH-1:0] w_ref;
    logic             zer_ref;
    logic             neg_ref;
    logic [WIDTH-1:0] w_dut;
    logic             zer_dut;
    logic             neg_dut;

    // Controller side: drives operands, observes both ALU results
    modport master (
        output a_out, b_out, c_out, func_out,
        input  w_ref, zer_ref, neg_ref, w_dut, zer_dut, neg_dut
    );

    // ALU-pair side: consumes operands, returns both results
    modport slave (
        input  a_out, b_out, c_out, func_out,
        output w_ref, zer_ref, neg_ref, w_dut, zer_dut, neg_dut
    );
endinterface
`default_nettype wire

// File: rtl/alu_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist_ctrl
// Brief    : On-chip self-test engine for a reference/structural ALU pair.
//            Sweeps func 0..7 with VECS_PER_OP LFSR vectors each, compares
//            {w, zero, neg} of both ALUs, counts mismatches (saturating) and
//            records the first failing func/vector.
// Revision : 1.0 - initial release
// ============================================================================
module alu_bist_ctrl #(
    parameter int                 WIDTH       = 16,
    parameter int                 VECS_PER_OP = 10,
    parameter logic [2*WIDTH:0]   SEED        = 33'h1_2345_6789
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    alu_bist_ctrl_if.master  alu,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [2:0]       first_err_func,
    output logic [9:0]       first_err_vec
);

    localparam int         c_LFSR_W     = 2 * WIDTH + 1;
    // Feedback taps: top bit and bit 19 of the 33-bit register
    localparam int         c_TAP_HI     = c_LFSR_W - 1;
    localparam int         c_TAP_LO     = 19;
    localparam logic [6:0] c_LAST_IN_OP = 7'(VECS_PER_OP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [c_LFSR_W-1:0] lfsr_q;
    logic [c_LFSR_W-1:0] lfsr_d;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                c_q;
    logic [2:0]          func_q;
    logic [9:0]          vec_idx_q;
    logic [6:0]          op_vec_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [7:0]          err_q;
    logic [7:0]          err_d;
    logic [2:0]          ferr_func_q;
    logic [9:0]          ferr_vec_q;
    logic                mismatch;
    logic                last_vec;

    // Next LFSR step, result comparison and saturating error increment
    always_comb begin
        lfsr_d   = {lfsr_q[c_LFSR_W-2:0], lfsr_q[c_TAP_HI] ^ lfsr_q[c_TAP_LO]};
        mismatch = (alu.w_ref != alu.w_dut) ||
                   (alu.zer_ref != alu.zer_dut) ||
                   (alu.neg_ref != alu.neg_dut);
        err_d    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        last_vec = (func_q == 3'd7) && (op_vec_q == c_LAST_IN_OP);
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            func_q      <= 3'd0;
            vec_idx_q   <= 10'd0;
            op_vec_q    <= 7'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 8'd0;
            ferr_func_q <= 3'd0;
            ferr_vec_q  <= 10'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // The all-zero vector is index 0 of func 0
                        state_q     <= ST_APPLY;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        err_q       <= 8'd0;
                        ferr_func_q <= 3'd0;
                        ferr_vec_q  <= 10'd0;
                        lfsr_q      <= SEED;
                        a_q         <= '0;
                        b_q         <= '0;
                        c_q         <= 1'b0;
                        func_q      <= 3'd0;
                        vec_idx_q   <= 10'd0;
                        op_vec_q    <= 7'd0;
                    end
                end
                ST_APPLY: begin
                    // Operands already stable; give the ALUs a full cycle
                    state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_q <= err_d;
                        if (err_q == 8'd0) begin
                            ferr_func_q <= func_q;
                            ferr_vec_q  <= vec_idx_q;
                        end
                    end
                    if (last_vec) begin
                        // Final verdict includes a mismatch on this last vector
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !mismatch && (err_q == 8'd0);
                    end else begin
                        state_q   <= ST_APPLY;
                        lfsr_q    <= lfsr_d;
                        a_q       <= lfsr_d[c_LFSR_W-1 -: WIDTH];
                        b_q       <= lfsr_d[WIDTH -: WIDTH];
                        c_q       <= lfsr_d[0];
                        vec_idx_q <= vec_idx_q + 10'd1;
                        if (op_vec_q == c_LAST_IN_OP) begin
                            op_vec_q <= 7'd0;
                            func_q   <= func_q + 3'd1;
                        end else begin
                            op_vec_q <= op_vec_q + 7'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu.a_out      = a_q;
    assign alu.b_out      = b_q;
    assign alu.c_out      = c_q;
    assign alu.func_out   = func_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_func = ferr_func_q;
    assign first_err_vec  = ferr_vec_q;

endmodule
`default_nettype wire
